// File: rtl/gate_unit_scheduler_pkg.sv
// Shared op codes and FSM state encoding for the gate unit scheduler.
package gate_unit_scheduler_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
  localparam logic [OP_W-1:0] OP_NAND = 3'd1;
  localparam logic [OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gate_unit_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or after ptr.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_req
);

  logic [IDW-1:0] idx;

  // Scan from the farthest slot back to ptr so the nearest hit is written last.
  always_comb begin
    idx       = '0;
    grant_idx = '0;
    any_req   = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + IDW'(k);
      if (req[idx]) grant_idx = idx;
    end
    grant = any_req ? (NREQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/gate_unit_scheduler.sv
// Time-shares one bitwise logic unit between NREQ requesters with round-robin grant.
// Accept at N, result valid at N+2 and held until resp_ready.
module gate_unit_scheduler
  import gate_unit_scheduler_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_data,
  output logic [IDW-1:0]        resp_id,
  output logic                  resp_err
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   rid_q, rid_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  arb_grant;
  logic [IDW-1:0]   arb_idx;
  logic             arb_any;

  logic [WIDTH-1:0] alu_data;
  logic             alu_err;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_comb begin
    alu_data = '0;
    alu_err  = 1'b0;
    case (op_q)
      OP_NOT:  alu_data = ~a_q;
      OP_NAND: alu_data = ~(a_q & b_q);
      OP_AND:  alu_data = a_q & b_q;
      OP_OR:   alu_data = a_q | b_q;
      OP_XOR:  alu_data = a_q ^ b_q;
      default: alu_err  = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    data_d  = data_q;
    rid_d   = rid_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          op_d    = req_op[3*int'(arb_idx) +: 3];
          a_d     = req_a[WIDTH*int'(arb_idx) +: WIDTH];
          b_d     = req_b[WIDTH*int'(arb_idx) +: WIDTH];
          id_d    = arb_idx;
          ptr_d   = arb_idx + IDW'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        data_d  = alu_data;
        rid_d   = id_q;
        err_d   = alu_err;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // Consuming cycle never grants; the next grant waits for IDLE.
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      data_q  <= '0;
      rid_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      data_q  <= data_d;
      rid_q   <= rid_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE && !reset) ? arb_grant : '0;
  assign resp_valid = (state_q == ST_DONE) && !reset;
  assign resp_data  = data_q;
  assign resp_id    = rid_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_gate_unit_scheduler.sv
// Bench for gate_unit_scheduler: directed scenarios plus random traffic against a
// transaction-level model (busy flag, cycles since accept, rotating pointer).
module tb_gate_unit_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [1:0]  resp_id;
  logic        resp_err;

  int tests_run;
  int tests_failed;

  int          m_ptr;
  bit          m_busy;
  int          m_age;
  logic [15:0] m_data;
  int          m_id;
  bit          m_err;
  int          last_grant;
  logic [3:0]  exp_ready;
  bit          exp_valid;

  gate_unit_scheduler #(.WIDTH(16), .NREQ(4), .IDW(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] ref_result(input int op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      0:       return ~a;
      1:       return ~(a & b);
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int first_req();
    for (int k = 0; k < 4; k++) begin
      if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_expect();
    int g;
    g = first_req();
    exp_ready = 4'b0000;
    if (!reset && !m_busy && g >= 0) exp_ready[g] = 1'b1;
    exp_valid = !reset && m_busy && (m_age == 2);
  endtask

  task automatic model_advance();
    int g;
    last_grant = -1;
    if (reset) begin
      m_busy = 0;
      m_ptr  = 0;
      m_age  = 0;
      return;
    end
    g = first_req();
    if (!m_busy && g >= 0) begin
      m_busy     = 1;
      m_age      = 1;
      m_data     = ref_result(int'(req_op[3*g +: 3]), req_a[16*g +: 16], req_b[16*g +: 16]);
      m_err      = req_op[3*g +: 3] > 3'd4;
      m_id       = g;
      m_ptr      = (g + 1) % 4;
      last_grant = g;
    end else if (m_busy) begin
      if (m_age == 2) begin
        if (resp_ready) m_busy = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic clk_edge();
    @(posedge clock);
    model_advance();
    #1;
  endtask

  task automatic settle();
    #1;
    model_expect();
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    req_op[3*i +: 3]  = op;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic randomize_operands();
    for (int i = 0; i < 4; i++)
      set_req(i, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
  endtask

  task automatic drain();
    req_valid  = 4'b0000;
    resp_ready = 1'b1;
    repeat (4) clk_edge();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 4'b1111;
    randomize_operands();
    for (int c = 0; c < 2; c++) begin
      clk_edge();
      settle();
      tests_run++;
      if ({req_ready, resp_valid, resp_data, resp_id, resp_err} !== 24'h0) begin
        tests_failed++;
        $display("FAIL reset_outputs cyc%0d: got rdy=%b vld=%b data=%h id=%0d err=%b required all zero",
                 c, req_ready, resp_valid, resp_data, resp_id, resp_err);
      end
    end
    reset     = 1'b0;
    req_valid = 4'b0000;
  endtask

  task automatic test_nand_single();
    req_valid  = 4'b0100;
    set_req(2, 3'd1, 16'h00FF, 16'h0F0F);
    resp_ready = 1'b1;
    settle();
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL nand_grant: got %b required 0100", req_ready);
    end
    clk_edge();
    req_valid = 4'b0000;
    settle();
    tests_run++;
    if ({req_ready, resp_valid} !== 5'b0) begin
      tests_failed++;
      $display("FAIL nand_exec_quiet: got rdy=%b vld=%b required 0000/0", req_ready, resp_valid);
    end
    clk_edge();
    settle();
    tests_run++;
    if ({resp_valid, resp_data, resp_id, resp_err} !== {1'b1, 16'hFFF0, 2'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL nand_result: got vld=%b data=%h id=%0d err=%b required 1/fff0/2/0",
               resp_valid, resp_data, resp_id, resp_err);
    end
    clk_edge();
    settle();
    tests_run++;
    if (resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL nand_consumed: got vld=%b required 0", resp_valid);
    end
  endtask

  task automatic test_round_robin();
    int grant_idx[$];
    int grant_cyc[$];
    int exp_idx[5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    clk_edge();
    reset      = 1'b0;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    randomize_operands();
    for (int c = 0; c < 15; c++) begin
      settle();
      tests_run++;
      if (req_ready !== exp_ready) begin
        tests_failed++;
        $display("FAIL rr_ready cyc%0d: got %b required %b", c, req_ready, exp_ready);
      end
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i] === 1'b1) begin
          grant_idx.push_back(i);
          grant_cyc.push_back(c);
        end
      end
      clk_edge();
    end
    tests_run++;
    if (grant_idx.size() != 5) begin
      tests_failed++;
      $display("FAIL rr_grant_count: got %0d required 5", grant_idx.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests_run++;
        if (grant_idx[k] != exp_idx[k] || grant_cyc[k] != 3 * k) begin
          tests_failed++;
          $display("FAIL rr_order #%0d: got id=%0d at cyc %0d required id=%0d at cyc %0d",
                   k, grant_idx[k], grant_cyc[k], exp_idx[k], 3 * k);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    req_valid  = 4'b0010;
    randomize_operands();
    resp_ready = 1'b0;
    settle();
    clk_edge();
    req_valid = 4'b1111;
    clk_edge();
    settle();
    held = resp_data;
    tests_run++;
    if (resp_valid !== 1'b1 || resp_data !== m_data || resp_id !== 2'd1) begin
      tests_failed++;
      $display("FAIL bp_first: got vld=%b data=%h id=%0d required 1/%h/1", resp_valid, resp_data, resp_id, m_data);
    end
    for (int c = 0; c < 5; c++) begin
      clk_edge();
      settle();
      tests_run++;
      if (resp_valid !== 1'b1 || resp_data !== held || req_ready !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bp_hold cyc%0d: got vld=%b data=%h rdy=%b required 1/%h/0000",
                 c, resp_valid, resp_data, req_ready, held);
      end
    end
    resp_ready = 1'b1;
    settle();
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL bp_consume_no_grant: got %b required 0000", req_ready);
    end
    clk_edge();
    resp_ready = 1'b0;
    settle();
    tests_run++;
    if (resp_valid !== 1'b0 || req_ready !== exp_ready || req_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL bp_release: got vld=%b rdy=%b required 0/0100", resp_valid, req_ready);
    end
    drain();
  endtask

  task automatic test_ops();
    int          ops[5]   = '{0, 2, 3, 4, 6};
    logic [15:0] datas[5] = '{16'h5A5A, 16'h05A0, 16'hAFF5, 16'hAA55, 16'h0000};
    bit          errs[5]  = '{0, 0, 0, 0, 1};
    int r;
    for (int k = 0; k < 5; k++) begin
      r = $urandom_range(0, 3);
      req_valid  = 4'b0000;
      req_valid[r] = 1'b1;
      set_req(r, 3'(ops[k]), 16'hA5A5, 16'h0FF0);
      resp_ready = 1'b1;
      settle();
      tests_run++;
      if (req_ready !== req_valid) begin
        tests_failed++;
        $display("FAIL op%0d_grant: got %b required %b", ops[k], req_ready, req_valid);
      end
      clk_edge();
      req_valid = 4'b0000;
      clk_edge();
      settle();
      tests_run++;
      if ({resp_valid, resp_data, resp_err, resp_id} !== {1'b1, datas[k], errs[k], 2'(r)}) begin
        tests_failed++;
        $display("FAIL op%0d_result: got vld=%b data=%h err=%b id=%0d required 1/%h/%b/%0d",
                 ops[k], resp_valid, resp_data, resp_err, resp_id, datas[k], errs[k], r);
      end
      clk_edge();
    end
  endtask

  task automatic test_reset_mid();
    req_valid  = 4'b0001;
    randomize_operands();
    resp_ready = 1'b1;
    settle();
    clk_edge();
    req_valid = 4'b0000;
    reset     = 1'b1;
    clk_edge();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      tests_run++;
      if (resp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_no_resp cyc%0d: got vld=%b required 0", c, resp_valid);
      end
      clk_edge();
    end
    req_valid = 4'b1001;
    settle();
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL midreset_ptr0: got %b required 0001", req_ready);
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 59) == 0);
      req_valid  = 4'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      randomize_operands();
      settle();
      tests_run++;
      if (req_ready !== exp_ready || resp_valid !== exp_valid) begin
        tests_failed++;
        $display("FAIL rand_hs cyc%0d: got rdy=%b vld=%b required rdy=%b vld=%b",
                 c, req_ready, resp_valid, exp_ready, exp_valid);
      end
      if (exp_valid) begin
        tests_run++;
        if ({resp_data, resp_id, resp_err} !== {m_data, 2'(m_id), m_err}) begin
          tests_failed++;
          $display("FAIL rand_resp cyc%0d: got data=%h id=%0d err=%b required %h/%0d/%b",
                   c, resp_data, resp_id, resp_err, m_data, m_id, m_err);
        end
      end
      clk_edge();
    end
    reset = 1'b0;
    drain();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_ptr        = 0;
    m_busy       = 0;
    m_age        = 0;
    m_data       = '0;
    m_id         = 0;
    m_err        = 0;
    last_grant   = -1;
    reset        = 1'b1;
    req_valid    = 4'b0000;
    req_op       = '0;
    req_a        = '0;
    req_b        = '0;
    resp_ready   = 1'b0;

    test_reset();
    test_nand_single();
    test_round_robin();
    test_backpressure();
    test_ops();
    test_reset_mid();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
